pc_fetch_sequencer: RTL

- Multi-cycle fetch/execute controller that sequences the program counter register.
- Issues instruction-memory requests, captures the returned instruction, and holds it while the datapath executes.
- Generates the PC `load` strobe and `PCSrc` select once per retired instruction.
- Detects EBREAK (halt) and instruction-memory timeout (fault).

---
 rtl/rv32_ctrl_pkg.sv | 17 +
 rtl/pc_fetch_sequencer_if.sv | 52 +++++
 rtl/fetch_timeout_counter.sv | 31 +++
 rtl/pc_fetch_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the RV32 control slice: sequencer states, the EBREAK
// encoding and the default word width.
package rv32_ctrl_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [31:0] EBREAK = 32'h00100073;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_FAULT = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory handshake, datapath handshake,
// PC control strobes and status flags.
interface pc_fetch_sequencer_if
   import rv32_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);

   logic            run;
   logic            imem_req;
   logic            imem_ready;
   logic [XLEN-1:0] imem_rdata;
   logic [XLEN-1:0] instr;
   logic            instr_valid;
   logic            stall;
   logic            branch_taken;
   logic            pc_load;
   logic            pc_src;
   logic            halted;
   logic            fault;

   modport master (
      input  run,
      input  imem_ready,
      input  imem_rdata,
      input  stall,
      input  branch_taken,
      output imem_req,
      output instr,
      output instr_valid,
      output pc_load,
      output pc_src,
      output halted,
      output fault
   );

   modport slave (
      output run,
      output imem_ready,
      output imem_rdata,
      output stall,
      output branch_taken,
      input  imem_req,
      input  instr,
      input  instr_valid,
      input  pc_load,
      input  pc_src,
      input  halted,
      input  fault
   );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Saturating wait counter for the fetch phase; expired flags TIMEOUT waited
// cycles so the sequencer can give up on a memory that never answers.
module fetch_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic Areset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Holds at LIMIT rather than wrapping so a stuck fetch can never look fresh.
   always_ff @(posedge clk or posedge Areset) begin
      if (Areset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/execute controller: fetches an instruction, holds it while
// the datapath executes, and strobes the PC once per retired instruction.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for run
// ST_FETCH | imem_req high, waiting for imem_ready (bounded by TIMEOUT)
// ST_EXEC  | instr_valid high; pc_load pulses on the first non-stall cycle
// ST_HALT  | EBREAK fetched; only reset leaves
// ST_FAULT | fetch timed out; only reset leaves
module pc_fetch_sequencer
   import rv32_ctrl_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  Areset,
   pc_fetch_sequencer_if.master bus
);

   seq_state_t state;
   seq_state_t state_nxt;

   logic fetch_done;
   logic is_ebreak;
   logic tmo_expired;
   logic tmo_clear;
   logic tmo_enable;

   assign fetch_done = (state == ST_FETCH) && bus.imem_ready;
   assign is_ebreak  = (bus.imem_rdata == XLEN'(EBREAK));
   assign tmo_clear  = (state != ST_FETCH) || bus.imem_ready;
   assign tmo_enable = (state == ST_FETCH) && !bus.imem_ready;

   fetch_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .Areset  (Areset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge Areset) begin
      if (Areset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge Areset) begin
      if (Areset) begin
         bus.instr <= '0;
      end else if (fetch_done) begin
         bus.instr <= bus.imem_rdata;
      end
   end

   always_comb begin
      state_nxt       = state;
      bus.imem_req    = 1'b0;
      bus.instr_valid = 1'b0;
      bus.pc_load     = 1'b0;
      bus.pc_src      = 1'b0;
      bus.halted      = 1'b0;
      bus.fault       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.run) begin
               state_nxt = ST_FETCH;
            end
         end

         // A ready arriving on the expiry cycle still completes the fetch.
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               state_nxt = is_ebreak ? ST_HALT : ST_EXEC;
            end else if (tmo_expired) begin
               state_nxt = ST_FAULT;
            end
         end

         ST_EXEC: begin
            bus.instr_valid = 1'b1;
            if (!bus.stall) begin
               bus.pc_load = 1'b1;
               bus.pc_src  = bus.branch_taken;
               state_nxt   = bus.run ? ST_FETCH : ST_IDLE;
            end
         end

         ST_HALT: begin
            bus.halted = 1'b1;
         end

         ST_FAULT: begin
            bus.fault = 1'b1;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
